// File: rtl/alu32_seq_ctrl.sv
// alu32_seq_ctrl
// Sequences a 32-bit operation through an external 16-bit ripple ALU in two
// passes: low half first, then high half. The carry between the halves is
// kept in a register. The assembled result and its flags are held on a
// valid/ready response handshake until the consumer takes them.
//
// Ports
//   clock, reset_n        : system clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_opcode            : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOR,
//                           101 SLT (signed), 110/111 illegal
//   req_a, req_b          : 32-bit operands
//   rsp_valid/rsp_ready   : response handshake
//   rsp_result            : 32-bit result
//   rsp_carry             : carry out of bit 31 (arithmetic ops only)
//   rsp_overflow          : signed overflow (arithmetic ops only)
//   rsp_zero              : result is zero (cleared for illegal opcodes)
//   rsp_err               : illegal opcode
//   alu_a, alu_b          : ALU operand half (0 outside LO/HI)
//   alu_ainvert/binvert   : ALU invert controls
//   alu_op                : 00 AND, 01 OR, 10 ADD
//   alu_cin               : ALU carry in
//   alu_out, alu_cout     : ALU result and carry out
module alu32_seq_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_ainvert,
  output logic        alu_binvert,
  output logic [1:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_out,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        carry_r;
  logic [31:0] result_r;
  logic        carry_out_r;
  logic        ovf_r;
  logic        zero_r;
  logic        err_r;

  logic [1:0]  ctl_op_s;
  logic        ctl_ainv_s;
  logic        ctl_binv_s;
  logic        ctl_cin_lo_s;
  logic        ctl_arith_s;
  logic        ctl_slt_s;
  logic [31:0] sum_s;
  logic        ovf_s;
  logic [31:0] final_s;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_SLT);
  endfunction

  // ALU control decode for the registered opcode.
  always_comb begin
    ctl_op_s     = ALU_AND;
    ctl_ainv_s   = 1'b0;
    ctl_binv_s   = 1'b0;
    ctl_cin_lo_s = 1'b0;
    ctl_arith_s  = 1'b0;
    ctl_slt_s    = 1'b0;
    case (op_r)
      OP_ADD: begin
        ctl_op_s    = ALU_ADD;
        ctl_arith_s = 1'b1;
      end
      OP_SUB: begin
        ctl_op_s     = ALU_ADD;
        ctl_binv_s   = 1'b1;
        ctl_cin_lo_s = 1'b1;
        ctl_arith_s  = 1'b1;
      end
      OP_SLT: begin
        ctl_op_s     = ALU_ADD;
        ctl_binv_s   = 1'b1;
        ctl_cin_lo_s = 1'b1;
        ctl_arith_s  = 1'b1;
        ctl_slt_s    = 1'b1;
      end
      OP_AND: ctl_op_s = ALU_AND;
      OP_OR:  ctl_op_s = ALU_OR;
      OP_NOR: begin
        // De Morgan: ~a & ~b == ~(a | b)
        ctl_op_s   = ALU_AND;
        ctl_ainv_s = 1'b1;
        ctl_binv_s = 1'b1;
      end
      default: ctl_op_s = ALU_AND;
    endcase
  end

  // High-half result assembly: overflow and SLT are decided from bit 31.
  always_comb begin
    sum_s = {alu_out, result_r[15:0]};
    ovf_s = ctl_arith_s && (a_r[31] == (b_r[31] ^ ctl_binv_s)) &&
            (alu_out[15] != a_r[31]);
    if (ctl_slt_s) begin
      final_s = {31'd0, alu_out[15] ^ ovf_s};
    end else begin
      final_s = sum_s;
    end
  end

  // ALU drive: combinational from state and registered operands.
  always_comb begin
    alu_a       = 16'd0;
    alu_b       = 16'd0;
    alu_ainvert = 1'b0;
    alu_binvert = 1'b0;
    alu_op      = 2'b00;
    alu_cin     = 1'b0;
    case (state_r)
      ST_LO: begin
        alu_a       = a_r[15:0];
        alu_b       = b_r[15:0];
        alu_ainvert = ctl_ainv_s;
        alu_binvert = ctl_binv_s;
        alu_op      = ctl_op_s;
        alu_cin     = ctl_cin_lo_s;
      end
      ST_HI: begin
        alu_a       = a_r[31:16];
        alu_b       = b_r[31:16];
        alu_ainvert = ctl_ainv_s;
        alu_binvert = ctl_binv_s;
        alu_op      = ctl_op_s;
        alu_cin     = carry_r;
      end
      default: alu_a = 16'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt_s = op_is_legal(req_opcode) ? ST_LO : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LO: state_nxt_s = ST_HI;
      ST_HI: state_nxt_s = ST_DONE;
      ST_DONE: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, half-result capture and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_r        <= 3'd0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      carry_r     <= 1'b0;
      result_r    <= 32'd0;
      carry_out_r <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r <= req_opcode;
            a_r  <= req_a;
            b_r  <= req_b;
            if (!op_is_legal(req_opcode)) begin
              result_r    <= 32'd0;
              carry_out_r <= 1'b0;
              ovf_r       <= 1'b0;
              zero_r      <= 1'b0;
              err_r       <= 1'b1;
            end
          end
        end
        ST_LO: begin
          result_r[15:0] <= alu_out;
          carry_r        <= alu_cout;
        end
        ST_HI: begin
          result_r    <= final_s;
          carry_out_r <= ctl_arith_s ? alu_cout : 1'b0;
          ovf_r       <= ovf_s;
          zero_r      <= (final_s == 32'd0);
          err_r       <= 1'b0;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign req_ready    = (state_r == ST_IDLE);
  assign rsp_valid    = (state_r == ST_DONE);
  assign rsp_result   = result_r;
  assign rsp_carry    = carry_out_r;
  assign rsp_overflow = ovf_r;
  assign rsp_zero     = zero_r;
  assign rsp_err      = err_r;

endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// Testbench for alu32_seq_ctrl: models the 16-bit ripple ALU beside the DUT,
// runs a directed vector table, random transactions against a 32-bit
// arithmetic reference model, backpressure and mid-operation reset.
module tb_alu32_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_overflow;
  logic        rsp_zero;
  logic        rsp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_ainvert;
  logic        alu_binvert;
  logic [1:0]  alu_op;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  alu32_seq_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ainvert(alu_ainvert),
    .alu_binvert(alu_binvert), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout)
  );

  // Behavioural 16-bit ALU that the controller drives.
  always_comb begin
    logic [15:0] aa;
    logic [15:0] bb;
    logic [16:0] s;
    aa = alu_ainvert ? ~alu_a : alu_a;
    bb = alu_binvert ? ~alu_b : alu_b;
    s  = {1'b0, aa} + {1'b0, bb} + {16'd0, alu_cin};
    alu_out  = 16'd0;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00: alu_out = aa & bb;
      2'b01: alu_out = aa | bb;
      2'b10: begin
        alu_out  = s[15:0];
        alu_cout = s[16];
      end
      default: alu_out = 16'd0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 32-bit reference built from plain arithmetic on whole operands.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic v,
                       output logic z, output logic e);
    logic [32:0] t;
    r = 32'd0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[31:0]; c = t[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1, 3'd5: begin
        t = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = t[31:0]; c = t[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
        if (op == 3'd5) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~(a | b);
      default: e = 1'b1;
    endcase
    z = (!e) && (r == 32'd0);
  endtask

  // Expected ALU controls during the low pass.
  task automatic exp_ctrl(input logic [2:0] op, output logic ai, output logic bi,
                          output logic [1:0] aop, output logic cin);
    ai = 1'b0; bi = 1'b0; aop = 2'b00; cin = 1'b0;
    case (op)
      3'd0: aop = 2'b10;
      3'd1, 3'd5: begin aop = 2'b10; bi = 1'b1; cin = 1'b1; end
      3'd2: aop = 2'b00;
      3'd3: aop = 2'b01;
      3'd4: begin ai = 1'b1; bi = 1'b1; end
      default: aop = 2'b00;
    endcase
  endtask

  // One full transaction starting at a negedge; returns response fields.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] r, output logic c,
                         output logic v, output logic z, output logic e,
                         output int lat, output logic hi_cin);
    int w;
    logic ai, bi, cl;
    logic [1:0] aop;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    @(posedge clock); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    req_opcode = 3'($urandom_range(0, 7));
    exp_ctrl(op, ai, bi, aop, cl);
    if (op < 3'd6) begin
      check("lo_alu_a", {16'd0, alu_a}, {16'd0, a[15:0]});
      check("lo_alu_b", {16'd0, alu_b}, {16'd0, b[15:0]});
      check("lo_ctrl", {27'd0, alu_ainvert, alu_binvert, alu_op, alu_cin},
            {27'd0, ai, bi, aop, cl});
    end else begin
      check("ill_alu_idle", {alu_a, alu_b}, 32'd0);
    end
    lat = 0; hi_cin = 1'b0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) begin
        hi_cin = alu_cin;
        check("hi_alu_a", {16'd0, alu_a}, {16'd0, a[31:16]});
      end
    end
    check("latency", lat, (op < 3'd6) ? 32'd2 : 32'd0);
    r = rsp_result; c = rsp_carry; v = rsp_overflow; z = rsp_zero; e = rsp_err;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_opcode = 3'd0; req_a = $urandom; req_b = $urandom;
      @(posedge clock); #1;
      check("bp_valid_ready", {30'd0, rsp_valid, req_ready}, 32'd2);
      check("bp_result", rsp_result, r);
      check("bp_flags", {28'd0, rsp_carry, rsp_overflow, rsp_zero, rsp_err},
            {28'd0, c, v, z, e});
      check("bp_alu_idle", {alu_a, alu_b}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    check("post_consume", {30'd0, rsp_valid, req_ready}, 32'd1);
    @(negedge clock);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        e;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] r, mr;
    logic c, v, z, e, mc, mv, mz, me, hc;
    int lat;
    logic [31:0] pick[5];

    vecs[0] = '{3'd0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{3'd5, 32'hFFFFFFFB, 32'h00000003, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{3'd5, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{3'd4, 32'h0F0F0000, 32'h00FF00FF, 32'hF000FF00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{3'd2, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{3'd3, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{3'd6, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0; req_valid = 1'b0; req_opcode = 3'd0;
    req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
    #1;
    check("reset_ready_valid", {30'd0, rsp_valid, req_ready}, 32'd1);
    check("reset_result", rsp_result, 32'd0);
    check("reset_flags", {28'd0, rsp_carry, rsp_overflow, rsp_zero, rsp_err}, 32'd0);
    check("reset_alu", {alu_a, alu_b, 9'd0, alu_ainvert, alu_binvert, alu_op, alu_cin}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed table; vector 0 also checks the inter-half carry, vector 5
    // exercises backpressure.
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, (i == 5) ? 5 : 0,
              r, c, v, z, e, lat, hc);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_flags", i), {28'd0, c, v, z, e},
            {28'd0, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].e});
      if (i == 0) check("add_hi_cin", {31'd0, hc}, 32'd1);
    end

    // Random transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      pick[0] = $urandom; pick[1] = 32'd0; pick[2] = 32'hFFFFFFFF;
      pick[3] = 32'h80000000; pick[4] = 32'h7FFFFFFF;
      a = pick[$urandom_range(0, 4)];
      pick[0] = $urandom;
      b = pick[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 0) b = $urandom;
      model(op, a, b, mr, mc, mv, mz, me);
      run_txn(op, a, b, $urandom_range(0, 2), r, c, v, z, e, lat, hc);
      check($sformatf("rnd%0d_result op%0d", i, op), r, mr);
      check($sformatf("rnd%0d_flags op%0d", i, op), {28'd0, c, v, z, e},
            {28'd0, mc, mv, mz, me});
    end

    // Reset while the high half is on the ALU.
    req_valid = 1'b1; req_opcode = 3'd0; req_a = 32'h00030005; req_b = 32'h00000007;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check("pre_reset_hi_alu_a", {16'd0, alu_a}, 32'h00000003);
    reset_n = 1'b0;
    #1;
    check("mid_reset_valid_ready", {30'd0, rsp_valid, req_ready}, 32'd1);
    check("mid_reset_result", rsp_result, 32'd0);
    check("mid_reset_flags", {28'd0, rsp_carry, rsp_overflow, rsp_zero, rsp_err}, 32'd0);
    check("mid_reset_alu", {alu_a, alu_b, 9'd0, alu_ainvert, alu_binvert, alu_op, alu_cin}, 32'd0);
    req_valid = 1'b1; req_opcode = 3'd1;
    @(posedge clock); #1;
    check("in_reset_no_accept", {30'd0, rsp_valid, req_ready}, 32'd1);
    check("in_reset_alu", {alu_a, alu_b}, 32'd0);
    req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_txn(3'd0, 32'd1, 32'd1, 0, r, c, v, z, e, lat, hc);
    check("after_reset_add", r, 32'd2);
    check("after_reset_flags", {28'd0, c, v, z, e}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
